// File: rtl/ram_access_arbiter.sv
// Two-port arbiter in front of the single MOV/MOC RAM; one access at a time, responses routed to the owner.
// Optional ram_moc watchdog enabled by defining RAM_ARB_TIMEOUT_EN (aborts with 32'hDEAD_BEEF and sticky err).
module ram_access_arbiter #(
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 64
) (
    input  logic        main_clk,
    input  logic        reset,
    input  logic        p0_mov,
    input  logic        p0_rw,
    input  logic        p0_sig,
    input  logic [1:0]  p0_dl,
    input  logic [8:0]  p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_moc,
    output logic [31:0] p0_rdata,
    input  logic        p1_mov,
    input  logic        p1_rw,
    input  logic        p1_sig,
    input  logic [1:0]  p1_dl,
    input  logic [8:0]  p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_moc,
    output logic [31:0] p1_rdata,
    output logic        ram_mov,
    output logic        ram_rw,
    output logic        ram_sig,
    output logic [1:0]  ram_dl,
    output logic [8:0]  ram_addr,
    output logic [31:0] ram_wdata,
    input  logic        ram_moc,
    input  logic [31:0] ram_rdata,
    output logic        owner,
    output logic        busy,
    output logic        err
);

    // state  | meaning
    // IDLE   | no access in flight, arbitrate pending requests
    // ACCESS | ram_mov held high, waiting for ram_moc
    // DONE   | owner moc high, waiting for owner to drop mov
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q;
    logic        ram_mov_q, ram_rw_q, ram_sig_q;
    logic [1:0]  ram_dl_q;
    logic [8:0]  ram_addr_q;
    logic [31:0] ram_wdata_q;
    logic        p0_moc_q, p1_moc_q;
    logic [31:0] p0_rdata_q, p1_rdata_q;
    logic        owner_q, busy_q, err_q;

    logic        win_d;
    logic        win_rw_d, win_sig_d;
    logic [1:0]  win_dl_d;
    logic [8:0]  win_addr_d;
    logic [31:0] win_wdata_d;
    logic        own_mov;
    logic        timeout_hit;
    logic [31:0] rsp_data;

    // On a tie, round-robin hands the grant to the port that did not own the last access.
    always_comb begin
        if (p0_mov && p1_mov) win_d = (RR_MODE != 0) ? ~owner_q : 1'b0;
        else                  win_d = ~p0_mov;
    end

    assign win_rw_d    = win_d ? p1_rw    : p0_rw;
    assign win_sig_d   = win_d ? p1_sig   : p0_sig;
    assign win_dl_d    = win_d ? p1_dl    : p0_dl;
    assign win_addr_d  = win_d ? p1_addr  : p0_addr;
    assign win_wdata_d = win_d ? p1_wdata : p0_wdata;
    assign own_mov     = owner_q ? p1_mov : p0_mov;
    assign rsp_data    = ram_moc ? ram_rdata : 32'hDEAD_BEEF;

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge main_clk) begin
        if (reset || state_q != ACCESS) cnt_q <= '0;
        else                            cnt_q <= cnt_q + 1'b1;
    end

    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge main_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ram_mov_q   <= 1'b0;
            ram_rw_q    <= 1'b0;
            ram_sig_q   <= 1'b0;
            ram_dl_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            p0_moc_q    <= 1'b0;
            p1_moc_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            owner_q     <= 1'b1;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (p0_mov || p1_mov) begin
                        owner_q     <= win_d;
                        ram_mov_q   <= 1'b1;
                        ram_rw_q    <= win_rw_d;
                        ram_sig_q   <= win_sig_d;
                        ram_dl_q    <= win_dl_d;
                        ram_addr_q  <= win_addr_d;
                        ram_wdata_q <= win_wdata_d;
                        busy_q      <= 1'b1;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (ram_moc || timeout_hit) begin
                        ram_mov_q <= 1'b0;
                        if (owner_q) begin
                            p1_moc_q   <= 1'b1;
                            p1_rdata_q <= rsp_data;
                        end else begin
                            p0_moc_q   <= 1'b1;
                            p0_rdata_q <= rsp_data;
                        end
                        if (!ram_moc) err_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!own_mov) begin
                        p0_moc_q <= 1'b0;
                        p1_moc_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_mov   = ram_mov_q;
    assign ram_rw    = ram_rw_q;
    assign ram_sig   = ram_sig_q;
    assign ram_dl    = ram_dl_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign p0_moc    = p0_moc_q;
    assign p1_moc    = p1_moc_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign owner     = owner_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
